// File: rtl/jpeg_mod_pkg.sv
// Shared types and geometry helpers for the block-to-HDMI frame scheduler.
package jpeg_mod_pkg;

   localparam int BLOCK_SIZE = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_CREDIT,
      STREAM,
      FRAME_END
   } sched_state_t;

   function automatic int beats_per_blk(input int n);
      return (BLOCK_SIZE * BLOCK_SIZE) / n;
   endfunction

endpackage

// File: rtl/blk_frame_sched_pos_cntr.sv
// Nested element/block/stripe position counter; advances on inc_i, clears on clr_i.
module blk_pos_cntr #(
   parameter int BEATS   = 32,
   parameter int BLKS    = 2,
   parameter int STRIPES = 2,
   parameter int EW      = (BEATS > 1) ? $clog2(BEATS) : 1,
   parameter int BW      = (BLKS > 1) ? $clog2(BLKS) : 1,
   parameter int SW      = (STRIPES > 1) ? $clog2(STRIPES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc_i,
   input  logic          clr_i,
   output logic [EW-1:0] elem_o,
   output logic [BW-1:0] blk_o,
   output logic [SW-1:0] stripe_o,
   output logic          last_elem_o,
   output logic          last_blk_o,
   output logic          last_stripe_o
);

   localparam logic [EW-1:0] ELEM_LAST   = EW'(BEATS - 1);
   localparam logic [BW-1:0] BLK_LAST    = BW'(BLKS - 1);
   localparam logic [SW-1:0] STRIPE_LAST = SW'(STRIPES - 1);

   logic [EW-1:0] elem_q;
   logic [BW-1:0] blk_q;
   logic [SW-1:0] stripe_q;

   assign last_elem_o   = (elem_q == ELEM_LAST);
   assign last_blk_o    = (blk_q == BLK_LAST);
   assign last_stripe_o = (stripe_q == STRIPE_LAST);
   assign elem_o        = elem_q;
   assign blk_o         = blk_q;
   assign stripe_o      = stripe_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         elem_q   <= '0;
         blk_q    <= '0;
         stripe_q <= '0;
      end else if (inc_i) begin
         if (last_elem_o) begin
            elem_q <= '0;
            if (last_blk_o) begin
               blk_q    <= '0;
               stripe_q <= last_stripe_o ? '0 : stripe_q + 1'b1;
            end else begin
               blk_q <= blk_q + 1'b1;
            end
         end else begin
            elem_q <= elem_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/blk_frame_sched.sv
// Frame scheduler: frames decoded block beats for the display converter and
// meters stripes against a two-entry ping-pong buffer credit counter.
module blk_frame_sched
   import jpeg_mod_pkg::*;
#(
   parameter int N     = 2,
   parameter int X_RES = 2160,
   parameter int Y_RES = 1200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                src_valid,
   output logic                src_ready,
   input  logic signed [N*8-1:0] src_data_y,
   input  logic signed [N*8-1:0] src_data_cr,
   input  logic signed [N*8-1:0] src_data_cb,
   input  logic                stripe_rd_done,
   output logic                blk_valid,
   output logic signed [N*8-1:0] blk_data_y,
   output logic signed [N*8-1:0] blk_data_cr,
   output logic signed [N*8-1:0] blk_data_cb,
   output logic                blk_sob,
   output logic                blk_eob,
   output logic                blk_sof,
   output logic                frame_done,
   output logic                credit_err
);

   // state       | meaning
   // IDLE        | parked, waiting for enable
   // WAIT_CREDIT | stripe boundary, waiting for a free stripe buffer
   // STREAM      | accepting beats of the current stripe
   // FRAME_END   | one-cycle frame_done, decide next frame or idle

   localparam int BEATS   = beats_per_blk(N);
   localparam int BLKS    = X_RES / BLOCK_SIZE;
   localparam int STRIPES = Y_RES / BLOCK_SIZE;
   localparam int EW      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BW      = (BLKS > 1) ? $clog2(BLKS) : 1;
   localparam int SW      = (STRIPES > 1) ? $clog2(STRIPES) : 1;

   sched_state_t state_q;
   logic [1:0]   credit_q, credit_d;
   logic         credit_err_q, credit_err_d;
   logic         credit_take;
   logic         xfer;

   logic                 blk_valid_q, blk_sob_q, blk_eob_q, blk_sof_q, frame_done_q;
   logic signed [N*8-1:0] data_y_q, data_cr_q, data_cb_q;

   logic [EW-1:0] elem;
   logic [BW-1:0] blk;
   logic [SW-1:0] stripe;
   logic          last_elem, last_blk, last_stripe;

   assign src_ready   = (state_q == STREAM);
   assign xfer        = src_valid && src_ready;
   assign credit_take = (state_q == WAIT_CREDIT) && (credit_q != 2'd0);

   blk_pos_cntr #(
      .BEATS   (BEATS),
      .BLKS    (BLKS),
      .STRIPES (STRIPES),
      .EW      (EW),
      .BW      (BW),
      .SW      (SW)
   ) u_pos (
      .clk           (clk),
      .rst           (rst),
      .inc_i         (xfer),
      .clr_i         ((state_q == IDLE) && enable),
      .elem_o        (elem),
      .blk_o         (blk),
      .stripe_o      (stripe),
      .last_elem_o   (last_elem),
      .last_blk_o    (last_blk),
      .last_stripe_o (last_stripe)
   );

   // A release and a take in the same cycle cancel; a release with both buffers free is an error.
   always_comb begin
      credit_d     = credit_q;
      credit_err_d = credit_err_q;
      if (stripe_rd_done && !credit_take) begin
         if (credit_q == 2'd2) credit_err_d = 1'b1;
         else                  credit_d     = credit_q + 2'd1;
      end else if (!stripe_rd_done && credit_take) begin
         credit_d = credit_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q     <= 2'd2;
         credit_err_q <= 1'b0;
      end else begin
         credit_q     <= credit_d;
         credit_err_q <= credit_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         blk_valid_q  <= 1'b0;
         blk_sob_q    <= 1'b0;
         blk_eob_q    <= 1'b0;
         blk_sof_q    <= 1'b0;
         frame_done_q <= 1'b0;
         data_y_q     <= '0;
         data_cr_q    <= '0;
         data_cb_q    <= '0;
      end else begin
         blk_valid_q  <= xfer;
         blk_sob_q    <= xfer && (elem == '0);
         blk_eob_q    <= xfer && last_elem;
         blk_sof_q    <= xfer && (elem == '0) && (blk == '0) && (stripe == '0);
         frame_done_q <= 1'b0;
         if (xfer) begin
            data_y_q  <= src_data_y;
            data_cr_q <= src_data_cr;
            data_cb_q <= src_data_cb;
         end
         case (state_q)
            IDLE:        if (enable) state_q <= WAIT_CREDIT;
            WAIT_CREDIT: if (credit_take) state_q <= STREAM;
            STREAM: begin
               if (xfer && last_elem && last_blk) begin
                  if (last_stripe) begin
                     state_q      <= FRAME_END;
                     frame_done_q <= 1'b1;
                  end else begin
                     state_q <= WAIT_CREDIT;
                  end
               end
            end
            FRAME_END:   state_q <= enable ? WAIT_CREDIT : IDLE;
            default:     state_q <= IDLE;
         endcase
      end
   end

   assign blk_valid   = blk_valid_q;
   assign blk_sob     = blk_sob_q;
   assign blk_eob     = blk_eob_q;
   assign blk_sof     = blk_sof_q;
   assign frame_done  = frame_done_q;
   assign credit_err  = credit_err_q;
   assign blk_data_y  = data_y_q;
   assign blk_data_cr = data_cr_q;
   assign blk_data_cb = data_cb_q;

endmodule

// File: tb/tb_blk_frame_sched.sv
// Directed + randomized bench for blk_frame_sched on a 16x16 frame with N=2.
module tb_blk_frame_sched;
   import jpeg_mod_pkg::*;

   localparam int N           = 2;
   localparam int BEATS_BLK   = 32;
   localparam int BEATS_FRAME = 128;

   logic clk = 1'b0;
   logic rst, enable, src_valid, src_ready, stripe_rd_done;
   logic signed [N*8-1:0] src_data_y, src_data_cr, src_data_cb;
   logic blk_valid, blk_sob, blk_eob, blk_sof, frame_done, credit_err;
   logic signed [N*8-1:0] blk_data_y, blk_data_cr, blk_data_cb;

   int checks = 0;
   int errors = 0;
   int out_idx = 0;
   int out_total = 0;
   bit rand_valid = 1'b0;
   logic [3*N*8-1:0] exp_q[$];

   always #5 clk = ~clk;

   blk_frame_sched #(.N(N), .X_RES(16), .Y_RES(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .src_valid      (src_valid),
      .src_ready      (src_ready),
      .src_data_y     (src_data_y),
      .src_data_cr    (src_data_cr),
      .src_data_cb    (src_data_cb),
      .stripe_rd_done (stripe_rd_done),
      .blk_valid      (blk_valid),
      .blk_data_y     (blk_data_y),
      .blk_data_cr    (blk_data_cr),
      .blk_data_cb    (blk_data_cb),
      .blk_sob        (blk_sob),
      .blk_eob        (blk_eob),
      .blk_sof        (blk_sof),
      .frame_done     (frame_done),
      .credit_err     (credit_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      src_data_y  = 16'($urandom);
      src_data_cr = 16'($urandom);
      src_data_cb = 16'($urandom);
      if (rand_valid) src_valid = 1'($urandom_range(0, 1));
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Reference: output beats replay accepted input beats in order; flags follow beat index in frame.
   task automatic monitor();
      logic [3*N*8-1:0] exp_beat;
      forever begin
         @(negedge clk);
         if (blk_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL beat_expected: observed unexpected beat, expected none queued");
            end
            if (exp_q.size() != 0) begin
               exp_beat = exp_q.pop_front();
               chk("data", {blk_data_y, blk_data_cr, blk_data_cb}, exp_beat);
               chk("sob", blk_sob, 64'(out_idx % BEATS_BLK == 0));
               chk("eob", blk_eob, 64'(out_idx % BEATS_BLK == BEATS_BLK - 1));
               chk("sof", blk_sof, 64'(out_idx == 0));
            end
            chk("frame_done_beat", frame_done, 64'(out_idx == BEATS_FRAME - 1));
            out_idx = (out_idx + 1) % BEATS_FRAME;
            out_total++;
         end else begin
            chk("frame_done_idle", frame_done, 64'd0);
         end
         if (rst) begin
            exp_q.delete();
            out_idx = 0;
         end else if (src_valid && src_ready) begin
            exp_q.push_back({src_data_y, src_data_cr, src_data_cb});
         end
      end
   endtask

   task automatic wait_frame_done(input string tag, input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   initial begin
      int acc;
      int rdy_seen;
      bit got;
      rst = 1'b1; enable = 1'b0; src_valid = 1'b0; stripe_rd_done = 1'b0;
      src_data_y = '0; src_data_cr = '0; src_data_cb = '0;
      fork monitor(); join_none

      // Scenario 1: reset values, then one frame with valid always high
      tick(); tick();
      chk("rst_src_ready", src_ready, 0);
      chk("rst_blk_valid", blk_valid, 0);
      chk("rst_flags", {blk_sob, blk_eob, blk_sof}, 0);
      chk("rst_data", {blk_data_y, blk_data_cr, blk_data_cb}, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_credit_err", credit_err, 0);
      chk("rst_state", 64'(dut.state_q), 64'(IDLE));
      chk("rst_credits", 64'(dut.credit_q), 2);
      rst = 1'b0; enable = 1'b1; src_valid = 1'b1; out_total = 0;
      wait_frame_done("s1_frame_done_seen", 400);
      chk("s1_credits_at_done", 64'(dut.credit_q), 0);
      tick();
      chk("s1_out_beats", 64'(out_total), BEATS_FRAME);
      chk("s1_state", 64'(dut.state_q), 64'(WAIT_CREDIT));
      chk("s1_src_ready", src_ready, 0);

      // Scenario 2: starve credits, then release one stripe buffer
      rdy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (src_ready) rdy_seen++;
         tick();
      end
      chk("s2_stalled", 64'(rdy_seen), 0);
      stripe_rd_done = 1'b1;
      tick();
      stripe_rd_done = 1'b0;
      chk("s2_ready_after_1", src_ready, 0);
      tick();
      chk("s2_ready_after_2", src_ready, 1);
      acc = 0;
      for (int i = 0; i < 200; i++) begin
         if (src_ready && src_valid) acc++;
         tick();
      end
      chk("s2_stripe_beats", 64'(acc), 64);
      chk("s2_stalled_again", src_ready, 0);
      chk("s2_state", 64'(dut.state_q), 64'(WAIT_CREDIT));

      // Scenario 3: random src_valid over a full frame
      pulse_rst();
      chk("s3_credits_rst", 64'(dut.credit_q), 2);
      rand_valid = 1'b1; out_total = 0;
      wait_frame_done("s3_frame_done_seen", 2000);
      tick();
      rand_valid = 1'b0; src_valid = 1'b0;
      chk("s3_out_beats", 64'(out_total), BEATS_FRAME);
      chk("s3_credits", 64'(dut.credit_q), 0);

      // Scenario 4: release coincident with credit take
      stripe_rd_done = 1'b1;
      tick();
      chk("s4_credits_pre", 64'(dut.credit_q), 1);
      chk("s4_state_pre", 64'(dut.state_q), 64'(WAIT_CREDIT));
      tick();
      stripe_rd_done = 1'b0;
      chk("s4_credits", 64'(dut.credit_q), 1);
      chk("s4_credit_err", credit_err, 0);
      chk("s4_state", 64'(dut.state_q), 64'(STREAM));
      src_valid = 1'b1; out_total = 0;
      wait_frame_done("s4_frame_done_seen", 400);
      tick();
      chk("s4_out_beats", 64'(out_total), BEATS_FRAME);
      chk("s4_credits_end", 64'(dut.credit_q), 0);

      // Scenario 5: over-release from reset
      enable = 1'b0; src_valid = 1'b0;
      pulse_rst();
      for (int k = 0; k < 3; k++) begin
         stripe_rd_done = 1'b1;
         tick();
         stripe_rd_done = 1'b0;
         chk("s5_credits", 64'(dut.credit_q), 2);
         chk("s5_credit_err", credit_err, 1);
         tick();
      end
      for (int i = 0; i < 10; i++) tick();
      chk("s5_err_sticky", credit_err, 1);
      pulse_rst();
      chk("s5_err_cleared", credit_err, 0);

      // Scenario 6: reset at beat 40, then clean restart
      enable = 1'b1; src_valid = 1'b1; acc = 0;
      for (int i = 0; i < 200; i++) begin
         if (src_ready && src_valid) begin
            if (acc == 40) break;
            acc++;
         end
         tick();
      end
      chk("s6_beat_index", 64'(acc), 40);
      pulse_rst();
      chk("s6_src_ready", src_ready, 0);
      chk("s6_blk_valid", blk_valid, 0);
      chk("s6_flags", {blk_sob, blk_eob, blk_sof}, 0);
      chk("s6_data", {blk_data_y, blk_data_cr, blk_data_cb}, 0);
      chk("s6_frame_done", frame_done, 0);
      chk("s6_state", 64'(dut.state_q), 64'(IDLE));
      chk("s6_credits", 64'(dut.credit_q), 2);
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (blk_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("s6_first_beat_seen", 64'(got), 1);
      chk("s6_first_sof", blk_sof, 1);
      wait_frame_done("s6_frame_done_seen", 400);
      tick();
      chk("s6_credits_end", 64'(dut.credit_q), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
